// File: rtl/tinysoc_prog_tx.sv
// Buffers a WORDS x 12-bit image, holds the target in reset for RST_CYC cycles, then streams 6-bit halves (lo first), one per cycle without stalls.
// FILL back-pressures through w_ready only. Optional build macro PROG_TX_CHKSUM_EN adds a chksum output (XOR of the words accepted in FILL).
module tinysoc_prog_tx #(
  parameter int WORDS   = 8,
  parameter int RST_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        w_valid,
  input  logic [11:0] w_data,
  output logic        w_ready,
  output logic        tgt_rst,
  output logic [5:0]  tgt_data,
  output logic        busy,
  output logic        done
`ifdef PROG_TX_CHKSUM_EN
  ,
  output logic [11:0] chksum
`endif
);

  localparam int WC_W = $clog2(WORDS);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RST,
    S_STREAM,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [WC_W-1:0]   wcnt_nxt;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              half_q, half_d;
  logic              tgt_rst_q, tgt_rst_d;
  logic [5:0]        tgt_data_q, tgt_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_we;
  logic [11:0]       mem_q [WORDS];

`ifdef PROG_TX_CHKSUM_EN
  logic [11:0]       chk_q, chk_d;
`endif

  assign wcnt_nxt = wcnt_q + WC_W'(1);

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    half_d     = half_q;
    tgt_rst_d  = tgt_rst_q;
    tgt_data_d = tgt_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    mem_we     = 1'b0;
`ifdef PROG_TX_CHKSUM_EN
    chk_d      = chk_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_FILL;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          tgt_rst_d = 1'b1;
          wcnt_d    = '0;
`ifdef PROG_TX_CHKSUM_EN
          chk_d     = '0;
`endif
        end
      end
      S_FILL: begin
        if (w_valid) begin
          mem_we = 1'b1;
`ifdef PROG_TX_CHKSUM_EN
          chk_d  = chk_q ^ w_data;
`endif
          if (wcnt_q == WC_LAST) begin
            state_d = S_RST;
            wcnt_d  = '0;
            rcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_nxt;
          end
        end
      end
      S_RST: begin
        // Release of the target and the first lo half land on the same edge.
        if (rcnt_q == RC_LAST) begin
          state_d    = S_STREAM;
          rcnt_d     = '0;
          half_d     = 1'b0;
          tgt_rst_d  = 1'b0;
          tgt_data_d = mem_q[0][5:0];
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      S_STREAM: begin
        if (!half_q) begin
          half_d     = 1'b1;
          tgt_data_d = mem_q[wcnt_q][11:6];
        end else if (wcnt_q == WC_LAST) begin
          state_d    = S_DONE;
          half_d     = 1'b0;
          wcnt_d     = '0;
          tgt_data_d = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          half_d     = 1'b0;
          wcnt_d     = wcnt_nxt;
          tgt_data_d = mem_q[wcnt_nxt][5:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      half_q     <= 1'b0;
      tgt_rst_q  <= 1'b1;
      tgt_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PROG_TX_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      half_q     <= half_d;
      tgt_rst_q  <= tgt_rst_d;
      tgt_data_q <= tgt_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PROG_TX_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Image storage is deliberately unreset; it is only read after a complete FILL.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wcnt_q] <= w_data;
    end
  end

  assign w_ready  = (state_q == S_FILL);
  assign tgt_rst  = tgt_rst_q;
  assign tgt_data = tgt_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef PROG_TX_CHKSUM_EN
  assign chksum   = chk_q;
`endif

endmodule

// File: tb/tb_tinysoc_prog_tx.sv
// Directed bench for tinysoc_prog_tx: reset, gap-free and gapped fills, stream order, start handling, async reset, optional chksum.
module tb_tinysoc_prog_tx;
  logic        clk;
  logic        rst;
  logic        start;
  logic        w_valid;
  logic [11:0] w_data;
  logic        w_ready;
  logic        tgt_rst;
  logic [5:0]  tgt_data;
  logic        busy;
  logic        done;
`ifdef PROG_TX_CHKSUM_EN
  logic [11:0] chksum;
`endif

  int          n_run  = 0;
  int          n_fail = 0;
  logic [11:0] img [8];

  tinysoc_prog_tx #(.WORDS(8), .RST_CYC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .tgt_rst  (tgt_rst),
    .tgt_data (tgt_data),
    .busy     (busy),
    .done     (done)
`ifdef PROG_TX_CHKSUM_EN
    ,
    .chksum   (chksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE or DONE; leaves the bench at the first negedge in FILL.
  task automatic begin_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_busy",    32'(busy),    32'd1);
    check("load_done",    32'(done),    32'd0);
    check("load_tgt_rst", 32'(tgt_rst), 32'd1);
    check("load_w_ready", 32'(w_ready), 32'd1);
  endtask

  task automatic fill_image(input bit gaps);
    int k   = 0;
    int cyc = 0;
    int rdy = 0;
    while (k < 8 && cyc < 64) begin
      w_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
      w_data  = img[k];
      if (w_ready) rdy++;
      if (w_valid && w_ready) k++;
      cyc++;
      @(negedge clk);
    end
    w_valid = 1'b0;
    w_data  = '0;
    check("fill_accepts",      32'(k),       32'd8);
    check("fill_ready_cycles", 32'(rdy),     gaps ? 32'd15 : 32'd8);
    check("fill_ready_low",    32'(w_ready), 32'd0);
  endtask

  // Entered at the first negedge after the final accept (state RST).
  task automatic stream_check(input bit poke_start);
    check("rst_hold_a", 32'(tgt_rst), 32'd1);
    @(negedge clk);
    check("rst_hold_b", 32'(tgt_rst), 32'd1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("tgt_rst_low%0d", k), 32'(tgt_rst), 32'd0);
      check($sformatf("lo%0d", k), 32'(tgt_data), 32'(img[k][5:0]));
      check($sformatf("busy%0d", k), 32'(busy), 32'd1);
      start = poke_start && (k == 3);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("hi%0d", k), 32'(tgt_data), 32'(img[k][11:6]));
      @(negedge clk);
    end
    check("end_done",     32'(done),     32'd1);
    check("end_busy",     32'(busy),     32'd0);
    check("end_data",     32'(tgt_data), 32'd0);
    check("end_tgt_rst",  32'(tgt_rst),  32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    w_valid = 1'b0;
    w_data  = '0;
    #2;
    check("rst_w_ready",  32'(w_ready),  32'd0);
    check("rst_tgt_rst",  32'(tgt_rst),  32'd1);
    check("rst_tgt_data", 32'(tgt_data), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy",    32'(busy),    32'd0);
    check("idle_tgt_rst", 32'(tgt_rst), 32'd1);

    // Ramp image, no gaps.
    for (int k = 0; k < 8; k++) img[k] = 12'(k);
    begin_load();
    fill_image(1'b0);
    stream_check(1'b0);
    @(negedge clk);
    check("done_hold", 32'(done), 32'd1);
    check("done_tgt_rst", 32'(tgt_rst), 32'd0);

    // Reload from DONE with gapped writes and a start pulse mid-stream.
    for (int k = 0; k < 8; k++) img[k] = 12'hA50 | 12'(k);
    begin_load();
    fill_image(1'b1);
    stream_check(1'b1);
    @(negedge clk);
    check("poke_done_hold", 32'(done), 32'd1);

    // Async reset in the middle of a stream.
    for (int k = 0; k < 8; k++) img[k] = 12'h7C3 ^ 12'(k * 12'h111);
    begin_load();
    fill_image(1'b0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_tgt_rst",  32'(tgt_rst),  32'd1);
    check("arst_tgt_data", 32'(tgt_data), 32'd0);
    check("arst_busy",     32'(busy),     32'd0);
    check("arst_done",     32'(done),     32'd0);
    check("arst_w_ready",  32'(w_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) img[k] = 12'h3A5 + 12'(k * 12'h0C1);
    begin_load();
    fill_image(1'b0);
    stream_check(1'b0);

    // Checksum image.
    img[0] = 12'hFFF;
    img[1] = 12'h0F0;
    img[2] = 12'h00F;
    for (int k = 3; k < 8; k++) img[k] = 12'h000;
    @(negedge clk);
    begin_load();
`ifdef PROG_TX_CHKSUM_EN
    check("chk_clear", 32'(chksum), 32'd0);
`endif
    fill_image(1'b1);
`ifdef PROG_TX_CHKSUM_EN
    check("chk_fill", 32'(chksum), 32'hF00);
`endif
    stream_check(1'b0);
`ifdef PROG_TX_CHKSUM_EN
    check("chk_stable", 32'(chksum), 32'hF00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
